// File: rtl/sixbit_operand_entry.sv
// Keypad operand front end: accumulates decimal digits, issues the operand to a function unit, captures its result.
// Optional build macro SIXBIT_ENTRY_NEG_EN adds a NEG key (two's-complement operand, 31 limit).
module sixbit_operand_entry #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_DIGITS    = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_valid,
    input  logic [3:0] i_key_code,
    output logic       o_key_ready,
    output logic [5:0] o_operand,
    output logic       o_operand_valid,
    input  logic [5:0] i_func_result,
    input  logic       i_func_ovf,
    output logic [5:0] o_result,
    output logic       o_result_ovf,
    output logic       o_result_valid,
    output logic       o_entry_ovf,
    output logic [1:0] o_dbg_state
);
    // Handshake: a key is consumed on a rising edge where i_key_valid && o_key_ready.
    // o_key_ready is high only in ENTRY; keys offered at other times are dropped, never queued.
    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam int CW  = $clog2(MAX_DIGITS + 1);
    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]  DIGIT_MAX   = CW'(MAX_DIGITS);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
`ifdef SIXBIT_ENTRY_NEG_EN
    localparam logic [3:0] KEY_NEG = 4'hC;
    localparam logic [5:0] LIMIT   = 6'd31;
`else
    localparam logic [5:0] LIMIT   = 6'd63;
`endif

    state_t         r_state;
    logic [5:0]     r_acc;
    logic [CW-1:0]  r_count;
    logic [SCW-1:0] r_settle;
    logic [5:0]     r_operand;
    logic [5:0]     r_result;
    logic           r_result_ovf;
    logic           r_result_valid;
    logic           r_entry_ovf;
`ifdef SIXBIT_ENTRY_NEG_EN
    logic           r_neg;
`endif

    logic [9:0] w_sum;
    logic       w_fire;
    logic       w_is_digit;
    logic [5:0] w_issue_val;

    // Widened so 63*10+9 cannot wrap before the saturation compare.
    assign w_sum      = ({4'd0, r_acc} * 10'd10) + {6'd0, i_key_code};
    assign w_fire     = i_key_valid && (r_state == ST_ENTRY);
    assign w_is_digit = (i_key_code <= 4'd9);
`ifdef SIXBIT_ENTRY_NEG_EN
    assign w_issue_val = r_neg ? (~r_acc + 6'd1) : r_acc;
`else
    assign w_issue_val = r_acc;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_ENTRY;
            r_acc          <= '0;
            r_count        <= '0;
            r_settle       <= '0;
            r_operand      <= '0;
            r_result       <= '0;
            r_result_ovf   <= 1'b0;
            r_result_valid <= 1'b0;
            r_entry_ovf    <= 1'b0;
`ifdef SIXBIT_ENTRY_NEG_EN
            r_neg          <= 1'b0;
`endif
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_ENTRY: begin
                    if (w_fire) begin
                        if (w_is_digit) begin
                            if (r_count < DIGIT_MAX) begin
                                r_count <= r_count + 1'b1;
                                if (w_sum > {4'd0, LIMIT}) begin
                                    r_acc       <= LIMIT;
                                    r_entry_ovf <= 1'b1;
                                end else begin
                                    r_acc <= w_sum[5:0];
                                end
                            end else begin
                                r_entry_ovf <= 1'b1;
                            end
                        end else begin
                            case (i_key_code)
                                KEY_CLEAR: begin
                                    r_acc       <= '0;
                                    r_count     <= '0;
                                    r_entry_ovf <= 1'b0;
`ifdef SIXBIT_ENTRY_NEG_EN
                                    r_neg       <= 1'b0;
`endif
                                end
                                KEY_ENTER: begin
                                    r_operand <= w_issue_val;
                                    r_settle  <= '0;
                                    r_state   <= ST_ISSUE;
                                end
`ifdef SIXBIT_ENTRY_NEG_EN
                                KEY_NEG: r_neg <= ~r_neg;
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // entry_ovf is folded in before it is cleared for the next operand.
                    r_result       <= i_func_result;
                    r_result_ovf   <= i_func_ovf | r_entry_ovf;
                    r_result_valid <= 1'b1;
                    r_acc          <= '0;
                    r_count        <= '0;
                    r_entry_ovf    <= 1'b0;
`ifdef SIXBIT_ENTRY_NEG_EN
                    r_neg          <= 1'b0;
`endif
                    r_state        <= ST_ENTRY;
                end
                default: r_state <= ST_ENTRY;
            endcase
        end
    end

    assign o_key_ready     = (r_state == ST_ENTRY);
    assign o_operand_valid = (r_state != ST_ENTRY);
    assign o_operand       = r_operand;
    assign o_result        = r_result;
    assign o_result_ovf    = r_result_ovf;
    assign o_result_valid  = r_result_valid;
    assign o_entry_ovf     = r_entry_ovf;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_sixbit_operand_entry.sv
// Bench for sixbit_operand_entry: vector table with a result scoreboard plus hand sequences for
// held keys during ISSUE, reset mid-ISSUE and reset colliding with a key.
module tb_sixbit_operand_entry;
    localparam int SETTLE = 2;
`ifdef SIXBIT_ENTRY_NEG_EN
    localparam int LIM = 31;
`else
    localparam int LIM = 63;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [5:0] operand;
    logic       operand_valid;
    logic [5:0] func_result;
    logic       func_ovf;
    logic [5:0] result;
    logic       result_ovf;
    logic       result_valid;
    logic       entry_ovf;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    sixbit_operand_entry #(.SETTLE_CYCLES(SETTLE), .MAX_DIGITS(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_key_valid(key_valid), .i_key_code(key_code),
        .o_key_ready(key_ready), .o_operand(operand), .o_operand_valid(operand_valid),
        .i_func_result(func_result), .i_func_ovf(func_ovf), .o_result(result),
        .o_result_ovf(result_ovf), .o_result_valid(result_valid), .o_entry_ovf(entry_ovf),
        .o_dbg_state(dbg_state)
    );

    typedef struct packed {
        logic [23:0] keys;
        logic [2:0]  nk;
        logic [5:0]  fres;
        logic        fovf;
        logic [5:0]  exp_op;
        logic        exp_eovf;
        logic [5:0]  exp_res;
        logic        exp_rovf;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         pulses = 0;

    always @(negedge clk) if (result_valid) pulses++;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        step();
        key_valid = 1'b0;
    endtask

    task automatic add_vec(input logic [23:0] keys, input int nk, input int fres, input int fovf,
                           input int op, input int eovf);
        vec_t v;
        v.keys     = keys;
        v.nk       = 3'(nk);
        v.fres     = 6'(fres);
        v.fovf     = 1'(fovf);
        v.exp_op   = 6'(op);
        v.exp_eovf = 1'(eovf);
        v.exp_res  = 6'(fres);
        v.exp_rovf = 1'(fovf | eovf);
        vecs.push_back(v);
    endtask

    // Presses ENTER, then follows the transaction through ISSUE to the result pulse.
    task automatic issue_and_capture(input logic [5:0] exp_op);
        int lat;
        logic [6:0] e;
        press(4'hB);
        check("issue_operand_valid", operand_valid, 1);
        check("issue_key_ready", key_ready, 0);
        check("issue_operand", operand, exp_op);
        lat = 1;
        while (!result_valid && lat < 20) begin
            step();
            if (!result_valid) check("issue_operand_stable", operand, exp_op);
            lat++;
        end
        check("latency", lat, SETTLE + 2);
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: got a result with 0 expected entries, required 1");
        end else begin
            e = exp_q.pop_front();
            check("result", result, e[5:0]);
            check("result_ovf", result_ovf, e[6]);
        end
        check("entry_ovf_cleared", entry_ovf, 0);
        check("back_in_entry", dbg_state, 0);
        step();
        check("result_valid_one_cycle", result_valid, 0);
    endtask

    task automatic run_vec(input vec_t v);
        for (int j = 0; j < int'(v.nk); j++) press(v.keys[4*j +: 4]);
        check("entry_ovf_before_enter", entry_ovf, v.exp_eovf);
        func_result = v.fres;
        func_ovf    = v.fovf;
        exp_q.push_back({v.exp_rovf, v.exp_res});
        issue_and_capture(v.exp_op);
    endtask

    initial begin
        int n;
        int p0;
        int d1;
        int d2;
        int val;
        logic ready_seen;
        logic [6:0] e;

`ifdef SIXBIT_ENTRY_NEG_EN
        add_vec(24'h0000C5, 2, 12, 0, 59, 0);
        add_vec(24'h000004, 2, 30, 0, 31, 1);
        add_vec(24'h0007CC, 3, 8,  0, 7,  0);
        add_vec(24'h000C13, 3, 2,  0, 33, 0);
        add_vec(24'h000023, 2, 19, 0, 31, 1);
`else
        add_vec(24'h000024, 2, 17, 0, 42, 0);
        add_vec(24'h000099, 2, 5,  0, 63, 1);
        add_vec(24'h000036, 2, 1,  0, 63, 0);
        add_vec(24'h000046, 2, 60, 0, 63, 1);
        add_vec(24'h00003C, 2, 14, 0, 3,  0);
`endif
        add_vec(24'h000321, 3, 40, 0, 12, 1);
        add_vec(24'h05A321, 5, 9,  1, 5,  0);
        add_vec(24'h000000, 0, 33, 0, 0,  0);
        add_vec(24'h000070, 2, 50, 0, 7,  0);
        add_vec(24'h0005E2, 3, 3,  1, 25, 0);
        add_vec(24'h003A99, 4, 27, 0, 3,  0);
        for (int r = 0; r < 6; r++) begin
            d1  = int'($urandom_range(0, 9));
            d2  = int'($urandom_range(0, 9));
            val = d1 * 10 + d2;
            add_vec({16'd0, 4'(d2), 4'(d1)}, 2, int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 1)), (val > LIM) ? LIM : val, (val > LIM) ? 1 : 0);
        end

        // Reset collides with a digit key: the key must be lost.
        rst = 1'b1; key_valid = 1'b1; key_code = 4'h5; func_result = '0; func_ovf = 1'b0;
        step();
        step();
        rst = 1'b0; key_valid = 1'b0;
        check("rst_state", dbg_state, 0);
        check("rst_key_ready", key_ready, 1);
        check("rst_operand", operand, 0);
        check("rst_operand_valid", operand_valid, 0);
        check("rst_result", result, 0);
        check("rst_result_ovf", result_ovf, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_entry_ovf", entry_ovf, 0);
        func_result = 6'd11;
        exp_q.push_back({1'b0, 6'd11});
        issue_and_capture(6'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // A key held valid through ISSUE/CAPTURE is never accepted.
        press(4'h8);
        func_result = 6'd21; func_ovf = 1'b0;
        exp_q.push_back({1'b0, 6'd21});
        key_valid = 1'b1; key_code = 4'hB;
        step();
        key_code = 4'h7;
        ready_seen = 1'b0;
        n = 0;
        while (!result_valid && n < 20) begin
            if (key_ready) ready_seen = 1'b1;
            step();
            n++;
        end
        key_valid = 1'b0;
        check("held_key_ready_low", ready_seen, 0);
        check("held_result_seen", result_valid, 1);
        check("held_operand", operand, 8);
        e = exp_q.pop_front();
        check("held_result", result, e[5:0]);
        func_result = 6'd44;
        exp_q.push_back({1'b0, 6'd44});
        issue_and_capture(6'd0);

        // Reset in the second ISSUE cycle aborts the transaction.
        press(4'h3);
        func_result = 6'd50;
        press(4'hB);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        p0 = pulses;
        check("abort_state", dbg_state, 0);
        check("abort_operand", operand, 0);
        check("abort_operand_valid", operand_valid, 0);
        check("abort_result", result, 0);
        check("abort_result_ovf", result_ovf, 0);
        check("abort_result_valid", result_valid, 0);
        check("abort_entry_ovf", entry_ovf, 0);
        repeat (6) step();
        check("abort_no_pulse", pulses - p0, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
